// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_arb_pkg;

  // Architectural register index width (x0..x31)
  localparam int unsigned REG_ADDR_W = 5;

  // Widest register the shared structs carry; DATA_WIDTH of the arbiter must not exceed it
  localparam int unsigned WB_DATA_W_MAX = 64;

  // One write-back request as presented by a functional unit
  typedef struct packed {
    logic [REG_ADDR_W-1:0]    waddr;
    logic [WB_DATA_W_MAX-1:0] wdata;
  } wb_req_t;

  // One register-file write port as driven by the arbiter
  typedef struct packed {
    logic [REG_ADDR_W-1:0]    waddr;
    logic [WB_DATA_W_MAX-1:0] wdata;
    logic                     we;
  } wb_port_t;

endpackage

// File: rtl/wb_rr_select.sv
// Combinational rotate-scan selector: walks the requesters starting at rr_i,
// accepts x0 writes for free and hands out up to NR_WPORTS nonzero grants,
// skipping any request whose destination collides with an earlier grant.
module wb_rr_select
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NR_REQ    = 4,
  parameter int unsigned NR_WPORTS = 2,
  parameter int unsigned IDX_W     = $clog2(NR_REQ),
  parameter int unsigned CNT_W     = $clog2(NR_WPORTS + 1)
) (
  input  logic [NR_REQ-1:0]                  valid_i,
  input  logic [NR_REQ-1:0][REG_ADDR_W-1:0]  waddr_i,
  input  logic [IDX_W-1:0]                   rr_i,
  output logic [NR_REQ-1:0]                  accept_o,
  output logic [NR_WPORTS-1:0][IDX_W-1:0]    port_idx_o,
  output logic [CNT_W-1:0]                   grant_cnt_o
);

  localparam logic [IDX_W:0]   NR_REQ_W    = (IDX_W + 1)'(NR_REQ);
  localparam logic [CNT_W-1:0] NR_WPORTS_W = CNT_W'(NR_WPORTS);

  logic [NR_REQ-1:0]               acc;
  logic [NR_WPORTS-1:0][IDX_W-1:0] idx_tab;
  logic [CNT_W-1:0]                cnt;
  logic [IDX_W:0]                  sum;
  logic [IDX_W-1:0]                idx;
  logic                            conflict;

  // Scan requesters in rotated order, filling ports in grant order
  always_comb begin
    acc      = '0;
    idx_tab  = '0;
    cnt      = '0;
    sum      = '0;
    idx      = '0;
    conflict = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      sum = {1'b0, rr_i} + (IDX_W + 1)'(k);
      idx = (sum >= NR_REQ_W) ? IDX_W'(sum - NR_REQ_W) : IDX_W'(sum);
      if (valid_i[idx]) begin
        if (waddr_i[idx] == '0) begin
          // x0 writes are discarded by the register file, so they cost no port
          acc[idx] = 1'b1;
        end else if (cnt < NR_WPORTS_W) begin
          conflict = 1'b0;
          for (int p = 0; p < NR_WPORTS; p++) begin
            if ((CNT_W'(p) < cnt) && (waddr_i[idx_tab[p]] == waddr_i[idx])) begin
              conflict = 1'b1;
            end
          end
          if (!conflict) begin
            acc[idx] = 1'b1;
            for (int p = 0; p < NR_WPORTS; p++) begin
              if (CNT_W'(p) == cnt) begin
                idx_tab[p] = idx;
              end
            end
            cnt = cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign accept_o    = acc;
  assign port_idx_o  = idx_tab;
  assign grant_cnt_o = cnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares NR_WPORTS register-file write ports among NR_REQ
// requesters in round-robin order and registers the winners onto the ports.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NR_REQ      = 4,
  parameter int unsigned NR_WPORTS   = 2,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NR_REQ-1:0]                     req_valid_i,
  output logic [NR_REQ-1:0]                     req_ready_o,
  input  logic [NR_REQ-1:0][REG_ADDR_W-1:0]     req_waddr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]     req_wdata_i,
  output logic [NR_WPORTS-1:0][REG_ADDR_W-1:0]  waddr_o,
  output logic [NR_WPORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
  output logic [NR_WPORTS-1:0]                  we_o,
  output logic [STALL_CNT_W-1:0]                stall_cnt_o
);

  localparam int unsigned    IDX_W    = $clog2(NR_REQ);
  localparam int unsigned    CNT_W    = $clog2(NR_WPORTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_REQ - 1);

  wb_req_t                         req [NR_REQ];
  wb_port_t                        port_reg [NR_WPORTS];
  logic [IDX_W-1:0]                rr_reg, rr_next;
  logic [STALL_CNT_W-1:0]          stall_reg, stall_next;
  logic [NR_REQ-1:0]               accept;
  logic [NR_WPORTS-1:0][IDX_W-1:0] port_idx;
  logic [CNT_W-1:0]                grant_cnt;
  logic [IDX_W-1:0]                last_idx;

  genvar gi;

  // Pack each requester's address/data into the shared request struct
  generate
    for (gi = 0; gi < NR_REQ; gi++) begin : g_req
      assign req[gi].waddr = req_waddr_i[gi];
      assign req[gi].wdata = WB_DATA_W_MAX'(req_wdata_i[gi]);
    end
  endgenerate

  wb_rr_select #(
    .NR_REQ    (NR_REQ),
    .NR_WPORTS (NR_WPORTS),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W)
  ) u_select (
    .valid_i     (req_valid_i),
    .waddr_i     (req_waddr_i),
    .rr_i        (rr_reg),
    .accept_o    (accept),
    .port_idx_o  (port_idx),
    .grant_cnt_o (grant_cnt)
  );

  // Ready is the raw accept mask, silenced during flush and while reset is held
  assign req_ready_o = (rst_ni && !flush_i) ? accept : '0;

  // Next scan start is one past the last nonzero grant; flush or no grant holds it
  always_comb begin
    last_idx = '0;
    for (int p = 0; p < NR_WPORTS; p++) begin
      if (CNT_W'(p + 1) == grant_cnt) begin
        last_idx = port_idx[p];
      end
    end
    rr_next = rr_reg;
    if (!flush_i && (grant_cnt != '0)) begin
      rr_next = (last_idx == LAST_IDX) ? '0 : last_idx + IDX_W'(1);
    end
  end

  // Count cycles where some valid request is left waiting, saturating at all-ones
  always_comb begin
    stall_next = stall_reg;
    if (!flush_i && (|(req_valid_i & ~accept)) && !(&stall_reg)) begin
      stall_next = stall_reg + STALL_CNT_W'(1);
    end
  end

  // Round-robin pointer and stall counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_reg    <= '0;
      stall_reg <= '0;
    end else begin
      rr_reg    <= rr_next;
      stall_reg <= stall_next;
    end
  end

  assign stall_cnt_o = stall_reg;

  // One registered write port per grant slot; idle ports keep address/data
  generate
    for (gi = 0; gi < NR_WPORTS; gi++) begin : g_port
      // Load the gi-th grant onto port gi, otherwise just drop its write enable
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          port_reg[gi] <= '0;
        end else if (!flush_i && (CNT_W'(gi) < grant_cnt)) begin
          port_reg[gi].waddr <= req[port_idx[gi]].waddr;
          port_reg[gi].wdata <= req[port_idx[gi]].wdata;
          port_reg[gi].we    <= 1'b1;
        end else begin
          port_reg[gi].we    <= 1'b0;
        end
      end

      assign waddr_o[gi] = port_reg[gi].waddr;
      assign wdata_o[gi] = port_reg[gi].wdata[DATA_WIDTH-1:0];
      assign we_o[gi]    = port_reg[gi].we;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized handshaking requesters, all compared to a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int NR_REQ  = 4;
  localparam int NWP     = 2;
  localparam int DW      = 64;
  localparam int SW      = 4;
  localparam int SAT     = (1 << SW) - 1;

  logic                       clk_i   = 1'b0;
  logic                       rst_ni  = 1'b0;
  logic                       flush_i = 1'b0;
  logic [NR_REQ-1:0]          req_valid = '0;
  logic [NR_REQ-1:0]          req_ready;
  logic [NR_REQ-1:0][4:0]     req_waddr = '0;
  logic [NR_REQ-1:0][DW-1:0]  req_wdata = '0;
  logic [NWP-1:0][4:0]        waddr_o;
  logic [NWP-1:0][DW-1:0]     wdata_o;
  logic [NWP-1:0]             we_o;
  logic [SW-1:0]              stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(
    .NR_REQ      (NR_REQ),
    .NR_WPORTS   (NWP),
    .DATA_WIDTH  (DW),
    .STALL_CNT_W (SW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_waddr_i (req_waddr),
    .req_wdata_i (req_wdata),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .we_o        (we_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // Reference model state
  int          m_rr;
  bit          m_we    [NWP];
  int          m_waddr [NWP];
  logic [63:0] m_wdata [NWP];
  int          m_stall;
  logic [3:0]  m_ready;
  int          g_addr [$];
  logic [63:0] g_data [$];
  int          g_last;
  logic [3:0]  obs_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_stall = 0;
    for (int p = 0; p < NWP; p++) begin
      m_we[p] = 0;
      m_waddr[p] = 0;
      m_wdata[p] = '0;
    end
  endtask

  // Decide this cycle's acceptances from the rules: rotate from m_rr, x0 free,
  // at most NWP nonzero grants, no duplicate destination among grants.
  task automatic model_eval();
    m_ready = '0;
    g_addr.delete();
    g_data.delete();
    g_last = -1;
    if (!flush_i) begin
      for (int k = 0; k < NR_REQ; k++) begin
        int i;
        bit busy;
        i = (m_rr + k) % NR_REQ;
        if (req_valid[i]) begin
          if (req_waddr[i] == 5'd0) begin
            m_ready[i] = 1'b1;
          end else if (g_addr.size() < NWP) begin
            busy = 0;
            foreach (g_addr[j]) if (g_addr[j] == int'(req_waddr[i])) busy = 1;
            if (!busy) begin
              m_ready[i] = 1'b1;
              g_addr.push_back(int'(req_waddr[i]));
              g_data.push_back(req_wdata[i]);
              g_last = i;
            end
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (!flush_i) begin
      for (int p = 0; p < NWP; p++) begin
        if (p < g_addr.size()) begin
          m_we[p] = 1;
          m_waddr[p] = g_addr[p];
          m_wdata[p] = g_data[p];
        end else begin
          m_we[p] = 0;
        end
      end
      if (g_last >= 0) m_rr = (g_last + 1) % NR_REQ;
      if (((req_valid & ~m_ready) != 0) && (m_stall < SAT)) m_stall++;
    end else begin
      for (int p = 0; p < NWP; p++) m_we[p] = 0;
    end
  endtask

  // One arbitration cycle: check ready mid-cycle, outputs just after the edge
  task automatic step();
    model_eval();
    @(negedge clk_i);
    obs_ready = req_ready;
    chk("ready", {60'd0, req_ready}, {60'd0, m_ready});
    @(posedge clk_i);
    #1;
    model_commit();
    cyc++;
    for (int p = 0; p < NWP; p++) begin
      chk($sformatf("we%0d", p), {63'd0, we_o[p]}, {63'd0, m_we[p]});
      chk($sformatf("waddr%0d", p), {59'd0, waddr_o[p]}, 64'(m_waddr[p]));
      chk($sformatf("wdata%0d", p), wdata_o[p], m_wdata[p]);
    end
    chk("stall", {60'd0, stall_cnt_o}, 64'(m_stall));
    $display("cyc %0d flush=%b valid=%b ready=%b we=%b port0=x%0d port1=x%0d stall=%0d",
             cyc, flush_i, req_valid, obs_ready, we_o, waddr_o[0], waddr_o[1], stall_cnt_o);
  endtask

  // Requesters honour the handshake: hold until accepted, then maybe re-present
  task automatic rand_update();
    for (int i = 0; i < NR_REQ; i++) begin
      if (!req_valid[i] || m_ready[i]) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          req_waddr[i] = 5'($urandom_range(0, 6));
          req_wdata[i] = {$urandom, $urandom};
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    flush_i = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    model_reset();

    // Reset held with requests pending: no ready may escape
    req_valid = 4'b1111;
    req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_we", {62'd0, we_o}, 64'd0);
    req_valid = '0;
    rst_ni = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) step();

    // Four requesters to x1..x4 from pointer 0
    req_valid = 4'b1111;
    req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int i = 0; i < NR_REQ; i++) req_wdata[i] = {$urandom, $urandom};
    step();
    chk("t2_ready0", {60'd0, obs_ready}, 64'b0011);
    chk("t2_we0", {62'd0, we_o}, 64'b11);
    chk("t2_port0", {54'd0, waddr_o[1], waddr_o[0]}, {54'd0, 5'd2, 5'd1});
    req_valid = 4'b1100;
    step();
    chk("t2_ready1", {60'd0, obs_ready}, 64'b1100);
    chk("t2_port1", {54'd0, waddr_o[1], waddr_o[0]}, {54'd0, 5'd4, 5'd3});
    chk("t2_stall", {60'd0, stall_cnt_o}, 64'd1);

    // Same destination from two requesters: second must wait
    req_valid = 4'b0011;
    req_waddr = {5'd0, 5'd0, 5'd5, 5'd5};
    req_wdata[0] = 64'hAAAA_0000_0000_0001;
    req_wdata[1] = 64'hBBBB_0000_0000_0002;
    step();
    chk("t3_ready0", {60'd0, obs_ready}, 64'b0001);
    chk("t3_we0", {62'd0, we_o}, 64'b01);
    chk("t3_waddr0", {59'd0, waddr_o[0]}, 64'd5);
    req_valid = 4'b0010;
    step();
    chk("t3_ready1", {60'd0, obs_ready}, 64'b0010);
    chk("t3_wdata1", wdata_o[0], 64'hBBBB_0000_0000_0002);

    // x0 write rides along with two real grants
    req_valid = 4'b0111;
    req_waddr = {5'd0, 5'd0, 5'd8, 5'd7};
    step();
    chk("t4_ready", {60'd0, obs_ready}, 64'b0111);
    chk("t4_we", {62'd0, we_o}, 64'b11);
    chk("t4_ports", {54'd0, waddr_o[1], waddr_o[0]}, {54'd0, 5'd8, 5'd7});

    // Flush: nothing accepted, pointer and stall counter hold
    req_valid = 4'b1111;
    req_waddr = {5'd12, 5'd11, 5'd10, 5'd9};
    flush_i = 1'b1;
    step();
    chk("t5_ready", {60'd0, obs_ready}, 64'd0);
    chk("t5_we", {62'd0, we_o}, 64'd0);
    chk("t5_stall", {60'd0, stall_cnt_o}, 64'd2);
    flush_i = 1'b0;
    step();
    chk("t5_rr_held", {60'd0, obs_ready}, 64'b1100);

    // Randomized handshaking traffic
    for (int c = 0; c < 300; c++) begin
      rand_update();
      step();
    end

    // Saturation with every requester continuously valid
    flush_i = 1'b0;
    req_valid = 4'b1111;
    req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NR_REQ; i++) if (m_ready[i]) req_wdata[i] = {$urandom, $urandom};
      step();
    end
    chk("t6_sat", {60'd0, stall_cnt_o}, 64'(SAT));

    // Asynchronous reset mid-cycle clears outputs before any clock edge
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_we", {62'd0, we_o}, 64'd0);
    chk("t6_rst_stall", {60'd0, stall_cnt_o}, 64'd0);
    chk("t6_rst_waddr", {54'd0, waddr_o[1], waddr_o[0]}, 64'd0);
    chk("t6_rst_wdata", wdata_o[0] | wdata_o[1], 64'd0);
    chk("t6_rst_ready", {60'd0, req_ready}, 64'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m_ready = '0;
    for (int c = 0; c < 20; c++) begin
      rand_update();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
